// File: rtl/instr_sequencer.sv
// instr_sequencer: loads up to DEPTH 16-bit instructions bytewise and issues them over valid/ready.
// Define SEQ_LOOP_EN to let loop_mode repeat the program until abort/clear.
module instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic          clear,
  input  logic          abort,
  input  logic          loop_mode,
  output logic [IW-1:0] inst_out,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic [7:0]    result_in,
  input  logic          zero_in,
  output logic [7:0]    last_result,
  output logic          last_zero,
  output logic [3:0]    count,
  output logic [7:0]    issued,
  output logic          busy,
  output logic          done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW:0] cnt;
  logic [AW-1:0] rd_ptr;
  logic [7:0] lo;
  logic lo_pend, lp, go, wr, last;
`ifdef SEQ_LOOP_EN
  assign lp = loop_mode;
`else
  assign lp = loop_mode & 1'b0;
`endif
  assign load_ready = (state == IDLE) && (cnt < FULL);
  assign go = start && (cnt != '0) && !lo_pend;
  assign wr = !clear && !go && load_valid && load_ready && lo_pend;
  assign last = ({1'b0, rd_ptr} == cnt - 1'b1);
  assign inst_valid = (state == RUN);
  assign inst_out = inst_valid ? mem[rd_ptr] : '0;
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign count = 4'(cnt);
  always_ff @(posedge clk)
    if (wr) mem[cnt[AW-1:0]] <= IW'({load_data, lo});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      lo_pend <= 1'b0;
      lo <= '0;
      rd_ptr <= '0;
      last_result <= '0;
      last_zero <= 1'b0;
      issued <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt <= '0;
      lo_pend <= 1'b0;
      rd_ptr <= '0;
      last_result <= '0;
      last_zero <= 1'b0;
      issued <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state <= RUN;
            rd_ptr <= '0;
            issued <= '0;
          end else if (load_valid && load_ready) begin
            lo_pend <= !lo_pend;
            if (lo_pend) cnt <= cnt + 1'b1;
            else lo <= load_data;
          end
        end
        RUN: begin
          if (inst_ready) begin
            last_result <= result_in;
            last_zero <= zero_in;
            issued <= issued + 1'b1;
            rd_ptr <= last ? '0 : rd_ptr + 1'b1;
            if (last && !lp) state <= DONE;
          end
        end
        default: begin
          if (start) begin
            state <= RUN;
            rd_ptr <= '0;
            issued <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; expected instruction words are queued at load and popped per accept.
module tb_instr_sequencer;
  logic clk = 0, rst_n = 0;
  logic load_valid = 0, start = 0, clear = 0, abort = 0, loop_mode = 0;
  logic [7:0] load_data = 0, result_in = 0;
  logic inst_ready = 0, zero_in = 0;
  logic load_ready, inst_valid, last_zero, busy, done;
  logic [15:0] inst_out;
  logic [7:0] last_result, issued;
  logic [3:0] count;
  int checks = 0, fails = 0;
  logic [15:0] exp_q [$];
  logic [15:0] e;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .clear(clear), .abort(abort),
    .loop_mode(loop_mode), .inst_out(inst_out), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .result_in(result_in), .zero_in(zero_in),
    .last_result(last_result), .last_zero(last_zero), .count(count),
    .issued(issued), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_valid = 1;
    load_data = w[7:0];
    tick();
    load_data = w[15:8];
    tick();
    load_valid = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic pulse_clear;
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    checks++; if (inst_valid !== 1'b0 || inst_out !== 16'h0) begin fails++; $display("FAIL reset_inst got v=%b d=%h exp v=0 d=0000", inst_valid, inst_out); end
    checks++; if (load_ready !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL reset_load got rdy=%b cnt=%0d exp rdy=1 cnt=0", load_ready, count); end
    checks++; if ({busy, done, issued, last_result, last_zero} !== 19'h0) begin fails++; $display("FAIL reset_status got b=%b d=%b iss=%0d lr=%h lz=%b exp all 0", busy, done, issued, last_result, last_zero); end
  endtask

  task automatic test_single;
    load_word(16'h1A33);
    checks++; if (count !== 4'd1 || load_ready !== 1'b1) begin fails++; $display("FAIL single_load got cnt=%0d rdy=%b exp cnt=1 rdy=1", count, load_ready); end
    exp_q.push_back(16'h1A33);
    pulse_start();
    inst_ready = 1;
    result_in = 8'h05;
    zero_in = 0;
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin fails++; $display("FAIL single_issue got v=%b d=%h exp v=1 d=%h", inst_valid, inst_out, e); end
    tick();
    inst_ready = 0;
    checks++; if (last_result !== 8'h05 || done !== 1'b1 || issued !== 8'd1) begin fails++; $display("FAIL single_done got lr=%h done=%b iss=%0d exp lr=05 done=1 iss=1", last_result, done, issued); end
    checks++; if (inst_valid !== 1'b0 || inst_out !== 16'h0) begin fails++; $display("FAIL single_idle_out got v=%b d=%h exp v=0 d=0000", inst_valid, inst_out); end
    pulse_clear();
    checks++; if (count !== 4'd0 || issued !== 8'd0 || last_result !== 8'h0 || done !== 1'b0) begin fails++; $display("FAIL clear got cnt=%0d iss=%0d lr=%h done=%b exp 0 0 00 0", count, issued, last_result, done); end
  endtask

  task automatic test_full;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom_range(0, 65535));
      exp_q.push_back(w);
      load_word(w);
    end
    checks++; if (load_ready !== 1'b0 || count !== 4'd8) begin fails++; $display("FAIL full got rdy=%b cnt=%0d exp rdy=0 cnt=8", load_ready, count); end
    load_valid = 1;
    load_data = 8'hAA;
    tick();
    tick();
    load_valid = 0;
    checks++; if (count !== 4'd8) begin fails++; $display("FAIL overfill got cnt=%0d exp 8", count); end
    pulse_start();
    inst_ready = 1;
    for (int i = 0; i < 8; i++) begin
      result_in = 8'(i * 3);
      e = exp_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || done !== 1'b0 || inst_out !== e) begin fails++; $display("FAIL b2b_%0d got v=%b done=%b d=%h exp v=1 done=0 d=%h", i, inst_valid, done, inst_out, e); end
      tick();
    end
    inst_ready = 0;
    checks++; if (done !== 1'b1 || issued !== 8'd8 || last_result !== 8'd21) begin fails++; $display("FAIL b2b_end got done=%b iss=%0d lr=%0d exp done=1 iss=8 lr=21", done, issued, last_result); end
    pulse_clear();
  endtask

  task automatic test_stall;
    logic [15:0] w [3];
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'h1111 * 16'(i + 1) ^ 16'h8001;
      exp_q.push_back(w[i]);
      load_word(w[i]);
    end
    pulse_start();
    inst_ready = 1;
    result_in = 8'h10;
    e = exp_q.pop_front();
    checks++; if (inst_out !== e) begin fails++; $display("FAIL stall_w0 got %h exp %h", inst_out, e); end
    tick();
    inst_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_out !== exp_q[0] || issued !== 8'd1) begin fails++; $display("FAIL stall_hold_%0d got v=%b d=%h iss=%0d exp v=1 d=%h iss=1", i, inst_valid, inst_out, issued, exp_q[0]); end
    end
    inst_ready = 1;
    e = exp_q.pop_front();
    checks++; if (inst_out !== e) begin fails++; $display("FAIL stall_w1 got %h exp %h", inst_out, e); end
    tick();
    result_in = 8'h00;
    zero_in = 1;
    e = exp_q.pop_front();
    checks++; if (inst_out !== e) begin fails++; $display("FAIL stall_w2 got %h exp %h", inst_out, e); end
    tick();
    inst_ready = 0;
    zero_in = 0;
    checks++; if (issued !== 8'd3 || last_zero !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL stall_end got iss=%0d lz=%b done=%b exp 3 1 1", issued, last_zero, done); end
    abort = 1;
    tick();
    abort = 0;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd3 || issued !== 8'd3) begin fails++; $display("FAIL abort_done got done=%b busy=%b cnt=%0d iss=%0d exp 0 0 3 3", done, busy, count, issued); end
    pulse_clear();
  endtask

  task automatic test_start_ignored;
    load_valid = 1;
    load_data = 8'h77;
    tick();
    load_valid = 0;
    pulse_start();
    checks++; if (busy !== 1'b0 || count !== 4'd0) begin fails++; $display("FAIL start_lopend got busy=%b cnt=%0d exp 0 0", busy, count); end
    pulse_start();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL start_empty got busy=%b exp 0", busy); end
    load_data = 8'h12;
    load_valid = 1;
    tick();
    load_valid = 0;
    clear = 1;
    start = 1;
    tick();
    clear = 0;
    start = 0;
    checks++; if (busy !== 1'b0 || count !== 4'd0 || load_ready !== 1'b1) begin fails++; $display("FAIL clear_start got busy=%b cnt=%0d rdy=%b exp 0 0 1", busy, count, load_ready); end
    load_word(16'hBEEF);
    exp_q.push_back(16'hBEEF);
    pulse_start();
    e = exp_q.pop_front();
    checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin fails++; $display("FAIL after_clear got v=%b d=%h exp v=1 d=%h", inst_valid, inst_out, e); end
    pulse_clear();
  endtask

  task automatic test_loop;
    load_word(16'hA0A1);
    load_word(16'hB0B2);
    loop_mode = 1;
    pulse_start();
    inst_ready = 1;
`ifdef SEQ_LOOP_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(i % 2 == 0 ? 16'hA0A1 : 16'hB0B2);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin fails++; $display("FAIL loop_%0d got v=%b d=%h exp v=1 d=%h", i, inst_valid, inst_out, e); end
      tick();
    end
    inst_ready = 0;
    checks++; if (issued !== 8'd5 || busy !== 1'b1) begin fails++; $display("FAIL loop_cnt got iss=%0d busy=%b exp 5 1", issued, busy); end
    abort = 1;
    tick();
    abort = 0;
`else
    exp_q.push_back(16'hA0A1);
    exp_q.push_back(16'hB0B2);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin fails++; $display("FAIL noloop_%0d got v=%b d=%h exp v=1 d=%h", i, inst_valid, inst_out, e); end
      tick();
    end
    inst_ready = 0;
    checks++; if (done !== 1'b1 || issued !== 8'd2) begin fails++; $display("FAIL noloop_done got done=%b iss=%0d exp 1 2", done, issued); end
    abort = 1;
    tick();
    abort = 0;
`endif
    loop_mode = 0;
    checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || count !== 4'd2) begin fails++; $display("FAIL loop_abort got v=%b busy=%b cnt=%0d exp 0 0 2", inst_valid, busy, count); end
  endtask

  task automatic test_async_reset;
    pulse_start();
    inst_ready = 1;
    e = 16'hA0A1;
    checks++; if (inst_out !== e) begin fails++; $display("FAIL rerun_w0 got %h exp %h", inst_out, e); end
    tick();
    inst_ready = 0;
    checks++; if (issued !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL pre_reset got iss=%0d busy=%b exp 1 1", issued, busy); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || issued !== 8'd0 || count !== 4'd0 || inst_out !== 16'h0) begin fails++; $display("FAIL async_reset got v=%b busy=%b iss=%0d cnt=%0d d=%h exp all 0", inst_valid, busy, issued, count, inst_out); end
    #2;
    rst_n = 1;
    tick();
    checks++; if (load_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL post_reset got rdy=%b done=%b exp 1 0", load_ready, done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_stall();
    test_start_ignored();
    test_loop();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
